// File: rtl/morty_pipeline_ctrl_if.sv
// morty_pipeline_ctrl_if
//   Groups the hazard-unit stall requests, the branch/WB status inputs and the
//   per-stage stall/flush/trap strobes of morty_pipeline_ctrl.
//   master : hazard unit / pipeline side (drives requests, receives strobes)
//   slave  : morty_pipeline_ctrl (receives requests, drives strobes)
//   CNT_W  : width of the stall-cycle counter
interface morty_pipeline_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             illegal_stall_req_i;
   logic             csr_stall_req_i;
   logic             ld_stall_req_i;
   logic             xcall_break_stall_req_i;
   logic             ex_branch_taken_i;
   logic             wb_exc_i;
   logic             if_stall_o;
   logic             id_stall_o;
   logic             id_flush_o;
   logic             ex_flush_o;
   logic             mem_flush_o;
   logic             trap_o;
   logic             pc_sel_trap_o;
   logic             drain_timeout_o;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cycles_o;

   modport master (
      output illegal_stall_req_i, csr_stall_req_i, ld_stall_req_i,
             xcall_break_stall_req_i, ex_branch_taken_i, wb_exc_i,
      input  if_stall_o, id_stall_o, id_flush_o, ex_flush_o, mem_flush_o,
             trap_o, pc_sel_trap_o, drain_timeout_o, state_o, stall_cycles_o
   );

   modport slave (
      input  illegal_stall_req_i, csr_stall_req_i, ld_stall_req_i,
             xcall_break_stall_req_i, ex_branch_taken_i, wb_exc_i,
      output if_stall_o, id_stall_o, id_flush_o, ex_flush_o, mem_flush_o,
             trap_o, pc_sel_trap_o, drain_timeout_o, state_o, stall_cycles_o
   );
endinterface

// File: rtl/morty_pipeline_ctrl.sv
// morty_pipeline_ctrl
//   Converts hazard-unit stall requests and EX branch resolution into per-stage
//   stall/flush strobes, sequences IDLE -> DRAIN -> TRAP -> REFILL so that an
//   excepting instruction retires in WB before the trap redirect, and counts
//   stalled cycles with saturation.
//   Ports:
//     clk_i  : clock, rising edge
//     rst_i  : synchronous active-high reset (also forces all strobes to 0)
//     bus    : morty_pipeline_ctrl_if slave modport (requests in, strobes out)
//   Parameters:
//     DRAIN_MAX : cycles in DRAIN before a forced trap (4..15)
//     CNT_W     : stall-cycle counter width
module morty_pipeline_ctrl #(
   parameter int DRAIN_MAX = 8,
   parameter int CNT_W     = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   morty_pipeline_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_TRAP   = 2'd2,
      ST_REFILL = 2'd3
   } state_t;

   localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r, state_s;
   logic [3:0]       drain_cnt_r, drain_cnt_s;
   logic             timeout_r, timeout_s;
   logic [CNT_W-1:0] stall_cnt_r;

   logic exc_s;
   logic if_stall_s, id_stall_s, id_flush_s, ex_flush_s, mem_flush_s;
   logic trap_s, pc_sel_trap_s, drain_timeout_s;

   assign exc_s = bus.illegal_stall_req_i | bus.xcall_break_stall_req_i;

   // Next-state logic and raw strobes decoded from state and requests.
   always_comb begin
      state_s         = state_r;
      drain_cnt_s     = drain_cnt_r;
      timeout_s       = timeout_r;
      if_stall_s      = 1'b0;
      id_stall_s      = 1'b0;
      id_flush_s      = 1'b0;
      ex_flush_s      = 1'b0;
      mem_flush_s     = 1'b0;
      trap_s          = 1'b0;
      pc_sel_trap_s   = 1'b0;
      drain_timeout_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A taken branch in EX kills the younger instructions that raised
            // any concurrent request; an older source re-requests next cycle.
            if (bus.ex_branch_taken_i) begin
               id_flush_s = 1'b1;
               ex_flush_s = 1'b1;
            end else if (exc_s) begin
               if_stall_s  = 1'b1;
               id_flush_s  = 1'b1;
               state_s     = ST_DRAIN;
               drain_cnt_s = 4'd0;
            end else if (bus.ld_stall_req_i | bus.csr_stall_req_i) begin
               if_stall_s = 1'b1;
               id_stall_s = 1'b1;
               ex_flush_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // Only the excepting instruction (or bubbles) moves toward WB.
            if_stall_s  = 1'b1;
            id_flush_s  = 1'b1;
            drain_cnt_s = drain_cnt_r + 4'd1;
            if (bus.wb_exc_i) begin
               state_s = ST_TRAP;
            end else if (drain_cnt_r == DRAIN_LAST) begin
               state_s   = ST_TRAP;
               timeout_s = 1'b1;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_TRAP: begin
            trap_s          = 1'b1;
            pc_sel_trap_s   = 1'b1;
            id_flush_s      = 1'b1;
            ex_flush_s      = 1'b1;
            mem_flush_s     = 1'b1;
            drain_timeout_s = timeout_r;
            timeout_s       = 1'b0;
            state_s         = ST_REFILL;
         end
         ST_REFILL: begin
            // Requests here come from already-flushed instructions.
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Strobes are forced low for the whole cycle in which reset is asserted.
   assign bus.if_stall_o      = if_stall_s      & ~rst_i;
   assign bus.id_stall_o      = id_stall_s      & ~rst_i;
   assign bus.id_flush_o      = id_flush_s      & ~rst_i;
   assign bus.ex_flush_o      = ex_flush_s      & ~rst_i;
   assign bus.mem_flush_o     = mem_flush_s     & ~rst_i;
   assign bus.trap_o          = trap_s          & ~rst_i;
   assign bus.pc_sel_trap_o   = pc_sel_trap_s   & ~rst_i;
   assign bus.drain_timeout_o = drain_timeout_s & ~rst_i;
   assign bus.state_o         = state_r;
   assign bus.stall_cycles_o  = stall_cnt_r;

   // State, drain counter, timeout flag and saturating stall counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r     <= ST_IDLE;
         drain_cnt_r <= 4'd0;
         timeout_r   <= 1'b0;
         stall_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_s;
         drain_cnt_r <= drain_cnt_s;
         timeout_r   <= timeout_s;
         if (if_stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end
endmodule

// File: tb/tb_morty_pipeline_ctrl.sv
// tb_morty_pipeline_ctrl
//   Table-driven directed bench for morty_pipeline_ctrl (DRAIN_MAX=8,
//   CNT_W=32) plus a hand-written saturation sequence on a CNT_W=4 instance.
//   Strobe vector order: {if_stall, id_stall, id_flush, ex_flush, mem_flush,
//   trap, pc_sel_trap, drain_timeout}.
module tb_morty_pipeline_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   morty_pipeline_ctrl_if #(.CNT_W(32)) bus  ();
   morty_pipeline_ctrl_if #(.CNT_W(4))  bus2 ();

   morty_pipeline_ctrl #(.DRAIN_MAX(8), .CNT_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   morty_pipeline_ctrl #(.DRAIN_MAX(8), .CNT_W(4)) dut2 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus2.slave)
   );

   typedef struct {
      logic        rst;
      logic        ill;
      logic        csr;
      logic        ld;
      logic        xb;
      logic        br;
      logic        wb;
      logic [7:0]  strb;
      logic [1:0]  st;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic ill, input logic csr, input logic ld,
                      input logic xb, input logic br, input logic wb,
                      input logic [7:0] strb, input logic [1:0] st, input logic [31:0] cnt);
      vec_t v;
      v.rst = r; v.ill = ill; v.csr = csr; v.ld = ld; v.xb = xb; v.br = br; v.wb = wb;
      v.strb = strb; v.st = st; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   function automatic logic [7:0] strobes();
      return {bus.if_stall_o, bus.id_stall_o, bus.id_flush_o, bus.ex_flush_o,
              bus.mem_flush_o, bus.trap_o, bus.pc_sel_trap_o, bus.drain_timeout_o};
   endfunction

   task automatic drive(input vec_t v);
      rst                         = v.rst;
      bus.illegal_stall_req_i     = v.ill;
      bus.csr_stall_req_i         = v.csr;
      bus.ld_stall_req_i          = v.ld;
      bus.xcall_break_stall_req_i = v.xb;
      bus.ex_branch_taken_i       = v.br;
      bus.wb_exc_i                = v.wb;
   endtask

   initial begin
      vec_t v;
      bus2.illegal_stall_req_i     = 1'b0;
      bus2.csr_stall_req_i         = 1'b0;
      bus2.ld_stall_req_i          = 1'b0;
      bus2.xcall_break_stall_req_i = 1'b0;
      bus2.ex_branch_taken_i       = 1'b0;
      bus2.wb_exc_i                = 1'b0;

      //   rst  ill  csr  ld   xb   br   wb   strobes       st    cnt
      // reset: strobes gated even with requests present, state/counter cleared
      add(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'b0000_0000,2'd0,32'd0);
      // load-use held two cycles
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd0,32'd0);
      add(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'b1101_0000,2'd0,32'd0);
      add(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'b1101_0000,2'd0,32'd1);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd0,32'd2);
      // branch beats load stall; CSR stall; branch beats exception
      add(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'b0011_0000,2'd0,32'd2);
      add(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'b1101_0000,2'd0,32'd2);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'b0011_0000,2'd0,32'd3);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd0,32'd3);
      // illegal drain, WB at N+3; requests ignored in DRAIN/TRAP/REFILL
      add(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'b1010_0000,2'd0,32'd3);
      add(1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,8'b1010_0000,2'd1,32'd4);
      add(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'b1010_0000,2'd1,32'd5);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'b1010_0000,2'd1,32'd6);
      add(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'b0011_1110,2'd2,32'd7);
      add(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'b0000_0000,2'd3,32'd7);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd0,32'd7);
      // xcall pulse, no WB: 8 DRAIN cycles then forced trap
      add(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'b1010_0000,2'd0,32'd7);
      for (int i = 0; i < 8; i++)
         add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b1010_0000,2'd1,32'(8 + i));
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0011_1111,2'd2,32'd16);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd3,32'd16);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd0,32'd16);
      // reset at second DRAIN cycle aborts with no trap
      add(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'b1010_0000,2'd0,32'd16);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b1010_0000,2'd1,32'd17);
      add(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd1,32'd18);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd0,32'd0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd0,32'd0);
      // WB in first DRAIN cycle; timeout flag must not linger
      add(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'b1010_0000,2'd0,32'd0);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'b1010_0000,2'd1,32'd1);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0011_1110,2'd2,32'd2);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd3,32'd2);
      add(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'b0000_0000,2'd0,32'd2);

      // one unchecked reset cycle so the first vector sees a defined state
      v = vecs[0];
      drive(v);
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         drive(v);
         @(negedge clk);
         checks++;
         if (strobes() !== v.strb) begin
            errors++;
            $display("FAIL vec%0d strobes: got %b want %b", i, strobes(), v.strb);
         end
         checks++;
         if (bus.state_o !== v.st) begin
            errors++;
            $display("FAIL vec%0d state: got %0d want %0d", i, bus.state_o, v.st);
         end
         checks++;
         if (bus.stall_cycles_o !== v.cnt) begin
            errors++;
            $display("FAIL vec%0d stall_cycles: got %0d want %0d", i, bus.stall_cycles_o, v.cnt);
         end
         @(posedge clk);
         #1;
      end

      // saturation on the 4-bit counter instance: 20 stalled cycles
      checks++;
      if (bus2.stall_cycles_o !== 4'd0) begin
         errors++;
         $display("FAIL sat_start: got %0d want 0", bus2.stall_cycles_o);
      end
      bus2.ld_stall_req_i = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus2.stall_cycles_o !== 4'((k > 15) ? 15 : k)) begin
            errors++;
            $display("FAIL sat_k%0d: got %0d want %0d", k, bus2.stall_cycles_o, (k > 15) ? 15 : k);
         end
      end
      bus2.ld_stall_req_i = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus2.stall_cycles_o !== 4'd15) begin
         errors++;
         $display("FAIL sat_hold: got %0d want 15", bus2.stall_cycles_o);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/morty_pipeline_ctrl.md
# morty_pipeline_ctrl

Pipeline control block for the Morty core, directly downstream of the hazard unit. It turns the hazard unit's stall requests (illegal, CSR, load, xcall/break) and the EX-stage branch resolution into per-stage stall and flush strobes. It runs a drain/trap state machine so an excepting instruction retires in WB before the trap redirect. It also keeps a saturating stall-cycle counter.

## Interface
- DRAIN_MAX, 8, max cycles in DRAIN before forced trap; legal range 4..15
- CNT_W, 32, width of stall cycle counter
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- illegal_stall_req_i  in  1  illegal instruction in ID/EX/MEM
- csr_stall_req_i  in  1  CSR data hazard
- ld_stall_req_i  in  1  load-use hazard
- xcall_break_stall_req_i  in  1  ecall/ebreak in ID/EX/MEM
- ex_branch_taken_i  in  1  taken branch/jump resolved in EX
- wb_exc_i  in  1  excepting instruction is in WB this cycle
- if_stall_o  out  1  hold PC and IF/ID register
- id_stall_o  out  1  hold ID/EX inputs (ID instruction re-decoded)
- id_flush_o  out  1  load bubble into IF/ID register
- ex_flush_o  out  1  load bubble into ID/EX register
- mem_flush_o  out  1  load bubble into EX/MEM register
- trap_o  out  1  one-cycle trap-taken strobe
- pc_sel_trap_o  out  1  select trap vector as next PC
- drain_timeout_o  out  1  trap was forced by DRAIN_MAX expiry (pulses with trap_o)
- state_o  out  2  FSM state: 0 IDLE, 1 DRAIN, 2 TRAP, 3 REFILL
- stall_cycles_o  out  CNT_W  saturating count of cycles with if_stall_o=1

## Operation
- Exception request: exc = illegal_stall_req_i | xcall_break_stall_req_i.
- State encoding: IDLE=0, DRAIN=1, TRAP=2, REFILL=3. Next state and counters are registered.
- Strobe outputs are combinational from state and inputs.

IDLE, priority order:
- **Branch** (ex_branch_taken_i): id_flush_o=1, ex_flush_o=1. Stay IDLE.
  - All stall and exception requests are ignored this cycle, because they belong to younger instructions.
  - If the request persists next cycle (source was older, in EX/MEM), it is handled then.
- **Exception** (exc): if_stall_o=1, id_flush_o=1. Go to DRAIN and clear the drain counter.
- **Load or CSR stall** (ld | csr): if_stall_o=1, id_stall_o=1, ex_flush_o=1. Stay IDLE.
- **Otherwise:** all strobes 0.

DRAIN:
- Outputs: if_stall_o=1, id_flush_o=1 every cycle. The excepting instruction advances while no new instruction enters.
- All request inputs and ex_branch_taken_i are ignored. In DRAIN, EX holds only the excepting instruction or a bubble.
- The drain counter increments each cycle.
- wb_exc_i=1: go to TRAP.
- Else, counter == DRAIN_MAX-1: go to TRAP with the timeout flag set.

TRAP (exactly one cycle):
- Outputs: trap_o=1, pc_sel_trap_o=1, id_flush_o=1, ex_flush_o=1, mem_flush_o=1, if_stall_o=0.
- drain_timeout_o = timeout flag. Clear the flag.
- Go to REFILL.

REFILL (exactly one cycle):
- All strobes 0. All requests are ignored, because they are stale flushed-instruction state.
- Go to IDLE.

stall_cycles_o:
- Increments on each cycle where if_stall_o=1.
- Holds at 2^CNT_W-1 (no wrap).

## Timing
- Reset, while rst_i=1:
  - All strobe outputs are forced to 0.
  - Next edge: state=IDLE, drain counter=0, timeout flag=0, stall_cycles_o=0.
- Reset mid-DRAIN/TRAP aborts with no trap_o pulse.
- Strobe latency is zero cycles (same-cycle combinational); state changes take effect the next edge.
- Exception seen in ID at cycle N, normal flow:
  - DRAIN during N+1..N+3.
  - wb_exc_i=1 at N+3.
  - TRAP at N+4, REFILL at N+5, IDLE at N+6.
- With no wb_exc_i, timeout forces TRAP at N+1+DRAIN_MAX.
- Exception in IDLE sets if_stall_o in cycle N itself, so stall_cycles_o counts N plus each DRAIN cycle.
- A load stall held k cycles adds k to stall_cycles_o.

## Test plan
- **Load-use:** IDLE, ld_stall_req_i=1 for 2 cycles -> if_stall_o=id_stall_o=ex_flush_o=1 for those 2 cycles. state_o stays 0; stall_cycles_o goes 0->2.
- **Branch beats stall:** ex_branch_taken_i=1 and ld_stall_req_i=1 in the same cycle -> id_flush_o=ex_flush_o=1, if_stall_o=0, id_stall_o=0. stall_cycles_o unchanged.
- **Illegal drain:** illegal_stall_req_i=1 at cycle 10, wb_exc_i=1 at cycle 13 ->
  - state_o=1 for 11..13, 2 at 14, 3 at 15, 0 at 16.
  - trap_o=pc_sel_trap_o=mem_flush_o=1 only at 14; drain_timeout_o=0.
- **Timeout:** DRAIN_MAX=8, xcall_break_stall_req_i pulse at cycle 0, wb_exc_i never asserted -> TRAP at cycle 9 with trap_o=1 and drain_timeout_o=1.
- **Reset mid-DRAIN:** enter DRAIN, assert rst_i at the second DRAIN cycle -> strobes 0 that cycle; next cycle state_o=0, stall_cycles_o=0. No trap_o ever.
- **Saturation:** CNT_W=4, ld_stall_req_i held 20 cycles -> stall_cycles_o reaches 15 and stays 15.
